// File: rtl/aes_job_arbiter_if.sv
// Request, response and core-side bundle for the AES job arbiter.
// slave is the arbiter's view of the bundle; master is the view of whatever drives it.
interface aes_job_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*128-1:0] req_data;
  logic [NUM_REQ*256-1:0] req_key;
  logic [NUM_REQ-1:0]     req_ready;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [127:0]           rsp_data;
  logic [ID_W-1:0]        rsp_id;
  logic                   rsp_err;

  logic                   core_start;
  logic [127:0]           core_data_in;
  logic [255:0]           core_key;
  logic [127:0]           core_data_out;
  logic                   core_valid;

  logic                   timeout_seen;

  modport slave (
    input  req_valid, req_data, req_key, rsp_ready, core_data_out, core_valid,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err,
           core_start, core_data_in, core_key, timeout_seen
  );

  modport master (
    output req_valid, req_data, req_key, rsp_ready, core_data_out, core_valid,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err,
           core_start, core_data_in, core_key, timeout_seen
  );
endinterface

// File: rtl/aes_job_arbiter.sv
// Round-robin arbiter sharing one AES encrypt core between NUM_REQ requesters,
// with a per-job timeout and a single tagged valid/ready response channel.
module aes_job_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ID_W           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic               clk,
  input logic               reset,
  aes_job_arbiter_if.slave  bus
);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    grant_q;
  logic [TMR_W-1:0]   timer;
  logic [127:0]       data_q;
  logic [255:0]       key_q;
  logic               core_start_q;
  logic               rsp_valid_q;
  logic [127:0]       rsp_data_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic               rsp_err_q;
  logic               timeout_seen_q;

  logic               any_c;
  logic [ID_W-1:0]    grant_c;
  logic [ID_W-1:0]    idx_c;
  logic [NUM_REQ-1:0] ready_c;

  // Round-robin search starting at ptr; the accept strobe is the only combinational output.
  always_comb begin
    any_c   = 1'b0;
    grant_c = '0;
    idx_c   = '0;
    ready_c = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx_c = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (!any_c && bus.req_valid[idx_c]) begin
        any_c   = 1'b1;
        grant_c = idx_c;
      end
    end
    if ((state == IDLE) && !reset && any_c) begin
      ready_c[grant_c] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= '0;
      grant_q        <= '0;
      timer          <= '0;
      data_q         <= '0;
      key_q          <= '0;
      core_start_q   <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_id_q       <= '0;
      rsp_err_q      <= 1'b0;
      timeout_seen_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_c) begin
            grant_q      <= grant_c;
            data_q       <= bus.req_data[32'(grant_c)*128 +: 128];
            key_q        <= bus.req_key[32'(grant_c)*256 +: 256];
            core_start_q <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          core_start_q <= 1'b0;
          timer        <= '0;
          state        <= BUSY;
        end
        BUSY: begin
          timer <= timer + TMR_W'(1);
          // A core result arriving on the last allowed cycle still counts as success.
          if (bus.core_valid) begin
            rsp_data_q  <= bus.core_data_out;
            rsp_err_q   <= 1'b0;
            rsp_id_q    <= grant_q;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_data_q     <= '0;
            rsp_err_q      <= 1'b1;
            rsp_id_q       <= grant_q;
            rsp_valid_q    <= 1'b1;
            timeout_seen_q <= 1'b1;
            state          <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ptr         <= ID_W'((32'(grant_q) + 32'd1) % NUM_REQ);
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = ready_c;
  assign bus.core_start   = core_start_q;
  assign bus.core_data_in = data_q;
  assign bus.core_key     = key_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.timeout_seen = timeout_seen_q;
endmodule
